// File: rtl/regfile_write_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_write_arbiter
//
// Purpose
//   Shares the single register-file write port between num_req_p writeback
//   sources (0 = integer pipe, 1 = remote-load response, 2 = divider/FPU).
//   The arbiter uses fixed priority with per-requester starvation escalation.
//   The winning write goes through one registered stage, and that stage
//   drives the regfile write port directly.
//
// Ports
//   clk_i       in   1                         clock
//   reset_i     in   1                         synchronous, active-high reset
//   req_v_i     in   num_req_p                 per-requester write valid
//   req_addr_i  in   num_req_p*addr_width_lp   per-requester destination reg
//   req_data_i  in   num_req_p*width_p         per-requester write data
//   req_yumi_o  out  num_req_p                 request consumed (one-hot or 0)
//   w_v_o       out  1                         regfile write enable (registered)
//   w_addr_o    out  addr_width_lp             regfile write address (registered)
//   w_data_o    out  width_p                   regfile write data (registered)
//   starved_o   out  num_req_p                 requester at its starvation limit
// -----------------------------------------------------------------------------
module regfile_write_arbiter #(
   parameter int width_p           = 32,
   parameter int els_p             = 32,
   parameter int num_req_p         = 3,
   parameter bit x0_tied_to_zero_p = 1'b1,
   parameter int starve_limit_p    = 4,
   localparam int addr_width_lp    = (els_p > 1) ? $clog2(els_p) : 1,
   localparam int cnt_width_lp     = (starve_limit_p + 1 > 1) ? $clog2(starve_limit_p + 1) : 1
) (
   input  logic                               clk_i,
   input  logic                               reset_i,
   input  logic [num_req_p-1:0]               req_v_i,
   input  logic [num_req_p*addr_width_lp-1:0] req_addr_i,
   input  logic [num_req_p*width_p-1:0]       req_data_i,
   output logic [num_req_p-1:0]               req_yumi_o,
   output logic                               w_v_o,
   output logic [addr_width_lp-1:0]           w_addr_o,
   output logic [width_p-1:0]                 w_data_o,
   output logic [num_req_p-1:0]               starved_o
);

   localparam logic [cnt_width_lp-1:0] limit_lp = cnt_width_lp'(starve_limit_p);

   // starvation counters, one per requester
   logic [num_req_p-1:0][cnt_width_lp-1:0] cnt_q, cnt_d;

   // write stage
   logic                     w_v_q,    w_v_d;
   logic [addr_width_lp-1:0] w_addr_q, w_addr_d;
   logic [width_p-1:0]       w_data_q, w_data_d;

   // grant decision for the current cycle
   logic                     gnt_v;
   logic [num_req_p-1:0]     gnt_oh;
   logic [addr_width_lp-1:0] gnt_addr;
   logic [width_p-1:0]       gnt_data;
   logic [num_req_p-1:0]     starved;

   // A requester is "starved" while its registered counter sits at the limit.
   always_comb begin
      starved = '0;
      for (int i = 0; i < num_req_p; i++) begin
         starved[i] = (cnt_q[i] == limit_lp);
      end
   end

   // Two-pass lowest-index search. The first pass looks only at starved
   // requesters. The second pass, used only if the first finds nothing,
   // looks at every valid requester. Reset masks every grant, so a
   // requester never sees yumi while the arbiter is being cleared.
   always_comb begin
      gnt_v    = 1'b0;
      gnt_oh   = '0;
      gnt_addr = '0;
      gnt_data = '0;
      if (!reset_i) begin
         for (int i = 0; i < num_req_p; i++) begin
            if (!gnt_v && req_v_i[i] && starved[i]) begin
               gnt_v     = 1'b1;
               gnt_oh[i] = 1'b1;
               gnt_addr  = req_addr_i[i*addr_width_lp +: addr_width_lp];
               gnt_data  = req_data_i[i*width_p +: width_p];
            end
         end
         for (int i = 0; i < num_req_p; i++) begin
            if (!gnt_v && req_v_i[i]) begin
               gnt_v     = 1'b1;
               gnt_oh[i] = 1'b1;
               gnt_addr  = req_addr_i[i*addr_width_lp +: addr_width_lp];
               gnt_data  = req_data_i[i*width_p +: width_p];
            end
         end
      end
   end

   // A counter only runs while its requester is waiting, and it saturates at
   // the limit. A grant clears it. So does dropping the request, which
   // happens when the source is flushed.
   always_comb begin
      cnt_d = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (req_v_i[i] && !gnt_oh[i]) begin
            cnt_d[i] = (cnt_q[i] == limit_lp) ? limit_lp : cnt_q[i] + cnt_width_lp'(1);
         end
      end
   end

   // A write to x0 is still consumed from the requester. When x0 is tied to
   // zero, that write is not issued to the regfile, and the address/data
   // registers keep their last real write.
   always_comb begin
      w_v_d    = 1'b0;
      w_addr_d = w_addr_q;
      w_data_d = w_data_q;
      if (gnt_v && !(x0_tied_to_zero_p && (gnt_addr == '0))) begin
         w_v_d    = 1'b1;
         w_addr_d = gnt_addr;
         w_data_d = gnt_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q    <= '0;
         w_v_q    <= 1'b0;
         w_addr_q <= '0;
         w_data_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         w_v_q    <= w_v_d;
         w_addr_q <= w_addr_d;
         w_data_q <= w_data_d;
      end
   end

   assign req_yumi_o = gnt_oh;
   assign starved_o  = starved;
   assign w_v_o      = w_v_q;
   assign w_addr_o   = w_addr_q;
   assign w_data_o   = w_data_q;

endmodule
